// File: rtl/hlsm_job_ctrl.sv
`timescale 1ns/1ps
// hlsm_job_ctrl: job controller in front of the HLSM scheduled kernel (a..g -> k,l).
// Latches one operand set per job, sequences Start/Done under a watchdog, holds results for valid/ready.
module hlsm_job_ctrl #(
  parameter int W          = 16,
  parameter int MAX_CYCLES = 64,
  parameter int CW         = 8
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] in_a,
  input  logic signed [W-1:0] in_b,
  input  logic signed [W-1:0] in_c,
  input  logic signed [W-1:0] in_d,
  input  logic signed [W-1:0] in_e,
  input  logic signed [W-1:0] in_f,
  input  logic signed [W-1:0] in_g,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] out_k,
  output logic signed [W-1:0] out_l,
  output logic                out_err,
  output logic [CW-1:0]       out_cycles,
  output logic                hls_start,
  output logic                hls_rst,
  output logic signed [W-1:0] hls_a,
  output logic signed [W-1:0] hls_b,
  output logic signed [W-1:0] hls_c,
  output logic signed [W-1:0] hls_d,
  output logic signed [W-1:0] hls_e,
  output logic signed [W-1:0] hls_f,
  output logic signed [W-1:0] hls_g,
  input  logic                hls_done,
  input  logic signed [W-1:0] hls_k,
  input  logic signed [W-1:0] hls_l
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_ABORT = 2'd2,
    S_HOLD  = 2'd3
  } state_e;

  localparam int            NOPS         = 7;
  localparam logic [CW-1:0] CNT_LAST     = CW'(MAX_CYCLES - 1);
  localparam logic [CW-1:0] CNT_DONE_MIN = CW'(2);

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic signed [W-1:0] opnd_q [NOPS];
  logic signed [W-1:0] opnd_d [NOPS];
  logic signed [W-1:0] in_ops_s [NOPS];
  logic                out_valid_q, out_valid_d;
  logic                out_err_q, out_err_d;
  logic signed [W-1:0] out_k_q, out_k_d;
  logic signed [W-1:0] out_l_q, out_l_d;
  logic [CW-1:0]       out_cycles_q, out_cycles_d;
  logic                done_s;
  logic                timeout_s;

  assign in_ops_s[0] = in_a;
  assign in_ops_s[1] = in_b;
  assign in_ops_s[2] = in_c;
  assign in_ops_s[3] = in_d;
  assign in_ops_s[4] = in_e;
  assign in_ops_s[5] = in_f;
  assign in_ops_s[6] = in_g;

  // Done from the previous run (or X before the first) is still visible for two cycles, so mask it.
  assign done_s    = (state_q == S_RUN) & hls_done & (cnt_q >= CNT_DONE_MIN);
  assign timeout_s = (state_q == S_RUN) & ~done_s & (cnt_q == CNT_LAST);

  // State register
  always_ff @(posedge Clk) begin
    if (Rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = S_RUN;   else state_d = S_IDLE;
      S_RUN: begin
        if (done_s)         state_d = S_HOLD;
        else if (timeout_s) state_d = S_ABORT;
        else                state_d = S_RUN;
      end
      S_ABORT: state_d = S_HOLD;
      S_HOLD:  if (out_ready) state_d = S_IDLE; else state_d = S_HOLD;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: operand latch, run counter, result capture
  always_comb begin
    cnt_d        = cnt_q;
    out_valid_d  = out_valid_q;
    out_err_d    = out_err_q;
    out_k_d      = out_k_q;
    out_l_d      = out_l_q;
    out_cycles_d = out_cycles_q;
    for (int i = 0; i < NOPS; i++) opnd_d[i] = opnd_q[i];
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          for (int i = 0; i < NOPS; i++) opnd_d[i] = in_ops_s[i];
          cnt_d = {CW{1'b0}};
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_RUN: begin
        if (cnt_q != CNT_LAST) cnt_d = cnt_q + CW'(1);
        else                   cnt_d = cnt_q;
        if (done_s) begin
          out_k_d      = hls_k;
          out_l_d      = hls_l;
          out_cycles_d = cnt_q;
          out_err_d    = 1'b0;
          out_valid_d  = 1'b1;
        end else begin
          out_valid_d  = out_valid_q;
        end
      end
      S_ABORT: begin
        out_k_d      = {W{1'b0}};
        out_l_d      = {W{1'b0}};
        out_err_d    = 1'b1;
        out_cycles_d = CNT_LAST;
        out_valid_d  = 1'b1;
      end
      S_HOLD: begin
        if (out_ready) out_valid_d = 1'b0;
        else           out_valid_d = out_valid_q;
      end
      default: cnt_d = cnt_q;
    endcase
  end

  // Datapath registers
  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt_q        <= {CW{1'b0}};
      out_valid_q  <= 1'b0;
      out_err_q    <= 1'b0;
      out_k_q      <= {W{1'b0}};
      out_l_q      <= {W{1'b0}};
      out_cycles_q <= {CW{1'b0}};
      for (int i = 0; i < NOPS; i++) opnd_q[i] <= {W{1'b0}};
    end else begin
      cnt_q        <= cnt_d;
      out_valid_q  <= out_valid_d;
      out_err_q    <= out_err_d;
      out_k_q      <= out_k_d;
      out_l_q      <= out_l_d;
      out_cycles_q <= out_cycles_d;
      for (int i = 0; i < NOPS; i++) opnd_q[i] <= opnd_d[i];
    end
  end

  // Output decode; Start must drop in the same cycle Done is seen so the kernel does not relaunch
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    hls_start = (state_q == S_RUN) & ~done_s & ~timeout_s;
    hls_rst   = Rst | (state_q == S_ABORT);
  end

  assign out_valid  = out_valid_q;
  assign out_err    = out_err_q;
  assign out_k      = out_k_q;
  assign out_l      = out_l_q;
  assign out_cycles = out_cycles_q;
  assign hls_a      = opnd_q[0];
  assign hls_b      = opnd_q[1];
  assign hls_c      = opnd_q[2];
  assign hls_d      = opnd_q[3];
  assign hls_e      = opnd_q[4];
  assign hls_f      = opnd_q[5];
  assign hls_g      = opnd_q[6];

endmodule

// File: tb/tb_hlsm_job_ctrl.sv
`timescale 1ns/1ps
// tb_hlsm_job_ctrl: randomized self-checking bench with a behavioural 12-cycle HLSM kernel
// and a job-level reference (result = kernel function of the operands, or abort tuple on a hang).
module tb_hlsm_job_ctrl;
  localparam int W = 16, MAXC = 64, CW = 8, KLAT = 12;
  typedef logic signed [W-1:0] word_t;

  logic Clk = 1'b0;
  logic Rst, in_valid, in_ready, out_valid, out_ready, out_err, hls_start, hls_rst, hls_done;
  word_t in_a, in_b, in_c, in_d, in_e, in_f, in_g, out_k, out_l, hls_k, hls_l;
  word_t hls_a, hls_b, hls_c, hls_d, hls_e, hls_f, hls_g;
  logic [CW-1:0] out_cycles;
  int checks = 0, errors = 0;

  hlsm_job_ctrl #(.W(W), .MAX_CYCLES(MAXC), .CW(CW)) dut (
    .Clk(Clk), .Rst(Rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d), .in_e(in_e), .in_f(in_f), .in_g(in_g),
    .out_valid(out_valid), .out_ready(out_ready), .out_k(out_k), .out_l(out_l),
    .out_err(out_err), .out_cycles(out_cycles), .hls_start(hls_start), .hls_rst(hls_rst),
    .hls_a(hls_a), .hls_b(hls_b), .hls_c(hls_c), .hls_d(hls_d), .hls_e(hls_e), .hls_f(hls_f),
    .hls_g(hls_g), .hls_done(hls_done), .hls_k(hls_k), .hls_l(hls_l));

  always #5 Clk = ~Clk;

  // Kernel function: k = b + c - a ; l = (f > g) ? e + g : e - g
  function automatic word_t ref_k(input word_t o [7]);
    return word_t'(o[1] + o[2] - o[0]);
  endfunction
  function automatic word_t ref_l(input word_t o [7]);
    return (o[5] > o[6]) ? word_t'(o[4] + o[6]) : word_t'(o[4] - o[6]);
  endfunction

  // Behavioural kernel: leaves state 0 on Start, raises Done 12 cycles later, sits in state 0 with Done=1
  word_t hls_ops [7];
  word_t klat [7];
  logic [3:0] kst;
  logic kdone;
  word_t kk, kl;
  bit kseen, kern_hang, op_moved, inj_en;
  logic inj_val;
  int launches, start_hi, rst_hi;
  assign hls_ops[0] = hls_a; assign hls_ops[1] = hls_b; assign hls_ops[2] = hls_c;
  assign hls_ops[3] = hls_d; assign hls_ops[4] = hls_e; assign hls_ops[5] = hls_f;
  assign hls_ops[6] = hls_g;
  assign hls_done = inj_en ? inj_val : (kseen ? kdone : 1'bx);
  assign hls_k = kk;
  assign hls_l = kl;

  always @(posedge Clk) begin
    if (hls_rst) begin
      kst <= 4'd0;
    end else if (kst == 4'd0) begin
      if (hls_start === 1'b1) begin
        kst <= 4'd1; kdone <= 1'b0; kseen <= 1'b1; launches <= launches + 1;
        for (int i = 0; i < 7; i++) klat[i] <= hls_ops[i];
      end
    end else begin
      for (int i = 0; i < 7; i++) if (hls_ops[i] !== klat[i]) op_moved <= 1'b1;
      if (kern_hang) kst <= kst;
      else if (kst == 4'(KLAT)) kst <= 4'd0;
      else begin
        kst <= kst + 4'd1;
        if (kst == 4'(KLAT - 1)) begin kk <= ref_k(klat); kl <= ref_l(klat); kdone <= 1'b1; end
      end
    end
  end

  always @(negedge Clk) begin
    if (hls_start === 1'b1) start_hi <= start_hi + 1;
    if (hls_rst === 1'b1 && Rst === 1'b0) rst_hi <= rst_hi + 1;
  end

  task automatic tick(); @(posedge Clk); #1; endtask

  task automatic set_ops(input word_t o [7]);
    in_a = o[0]; in_b = o[1]; in_c = o[2]; in_d = o[3]; in_e = o[4]; in_f = o[5]; in_g = o[6];
  endtask

  task automatic rand_ops(output word_t o [7]);
    for (int i = 0; i < 7; i++) o[i] = word_t'($urandom);
  endtask

  // Present a job and return just after the accepting edge (RUN, cnt=0)
  task automatic accept(input word_t o [7], output bit ok);
    set_ops(o); in_valid = 1'b1; ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (in_ready === 1'b1) begin ok = 1'b1; break; end
      tick();
    end
    tick(); in_valid = 1'b0;
  endtask

  task automatic wait_out(output bit ok, output int lat);
    ok = 1'b0; lat = 0;
    for (int i = 0; i < 200; i++) begin
      if (out_valid === 1'b1) begin ok = 1'b1; break; end
      tick(); lat++;
    end
  endtask

  task automatic take(); out_ready = 1'b1; tick(); out_ready = 1'b0; endtask

  task automatic test_reset();
    Rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; inj_en = 1'b0; inj_val = 1'b0; kern_hang = 1'b0;
    in_a = '0; in_b = '0; in_c = '0; in_d = '0; in_e = '0; in_f = '0; in_g = '0;
    tick(); tick();
    checks++; if ({hls_rst, hls_start, out_valid, out_err} !== 4'b1000) begin
      errors++; $display("FAIL reset_ctl got %b want 1000", {hls_rst, hls_start, out_valid, out_err}); end
    checks++; if ({out_k, out_l, out_cycles} !== {(2*W+CW){1'b0}}) begin
      errors++; $display("FAIL reset_out got %h want 0", {out_k, out_l, out_cycles}); end
    checks++; if ({hls_a, hls_b, hls_c, hls_d, hls_e, hls_f, hls_g} !== {(7*W){1'b0}}) begin
      errors++; $display("FAIL reset_ops got %h want 0", {hls_a, hls_b, hls_c, hls_d, hls_e, hls_f, hls_g}); end
    Rst = 1'b0; #1;
    checks++; if ({hls_rst, in_ready} !== 2'b01) begin
      errors++; $display("FAIL reset_release got %b want 01", {hls_rst, in_ready}); end
  endtask

  task automatic test_nominal();
    word_t o [7];
    bit ok; int lat, s0, l0;
    o = '{16'sd3, 16'sd4, 16'sd5, 16'sd6, 16'sd7, 16'sd100, 16'sd7};
    s0 = start_hi; l0 = launches;
    accept(o, ok);
    wait_out(ok, lat);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL nom_timeout got no out_valid want out_valid"); end
    checks++; if ({out_k, out_l} !== {16'sd6, 16'sd14}) begin
      errors++; $display("FAIL nom_kl got %0d,%0d want 6,14", out_k, out_l); end
    checks++; if ({out_err, out_cycles} !== {1'b0, 8'd12}) begin
      errors++; $display("FAIL nom_cyc got err=%b cyc=%0d want err=0 cyc=12", out_err, out_cycles); end
    checks++; if (start_hi - s0 !== 12 || launches - l0 !== 1) begin
      errors++; $display("FAIL nom_start got start=%0d launches=%0d want 12,1", start_hi - s0, launches - l0); end
    take();
    checks++; if ({out_valid, in_ready} !== 2'b01) begin
      errors++; $display("FAIL nom_take got %b want 01", {out_valid, in_ready}); end
  endtask

  task automatic test_hold();
    word_t o [7]; word_t n [7];
    bit ok; int lat, l0, bad;
    rand_ops(o); rand_ops(n);
    accept(o, ok);
    wait_out(ok, lat);
    l0 = launches; bad = 0;
    set_ops(n); in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      checks++;
      if ({out_valid, in_ready, hls_start, out_k, out_l, hls_a, hls_g} !==
          {1'b1, 1'b0, 1'b0, ref_k(o), ref_l(o), o[0], o[6]}) begin
        errors++; $display("FAIL hold_stable cyc %0d got k=%0d l=%0d v=%b r=%b s=%b want k=%0d l=%0d v=1 r=0 s=0",
          i, out_k, out_l, out_valid, in_ready, hls_start, ref_k(o), ref_l(o));
      end
      tick();
    end
    in_valid = 1'b0;
    checks++; if (launches !== l0) begin errors++; $display("FAIL hold_relaunch got %0d want %0d", launches, l0); end
    take();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_take got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    word_t a [7]; word_t b [7];
    bit ok; int lat;
    rand_ops(a);
    b = '{-16'sd8, 16'sd2, -16'sd5, 16'sd9, -16'sd3, 16'sd1, 16'sd4};
    out_ready = 1'b1; set_ops(a); in_valid = 1'b1;
    for (int i = 0; i < 50 && in_ready !== 1'b1; i++) tick();
    tick(); set_ops(b);
    checks++; if ({in_ready, hls_a} !== {1'b0, a[0]}) begin
      errors++; $display("FAIL b2b_accA got r=%b a=%0d want r=0 a=%0d", in_ready, hls_a, a[0]); end
    wait_out(ok, lat);
    checks++; if ({ok, out_k, out_l} !== {1'b1, ref_k(a), ref_l(a)}) begin
      errors++; $display("FAIL b2b_resA got k=%0d l=%0d want k=%0d l=%0d", out_k, out_l, ref_k(a), ref_l(a)); end
    tick();
    checks++; if ({in_ready, out_valid, hls_a} !== {1'b1, 1'b0, a[0]}) begin
      errors++; $display("FAIL b2b_gap got r=%b v=%b a=%0d want r=1 v=0 a=%0d", in_ready, out_valid, hls_a, a[0]); end
    tick(); in_valid = 1'b0;
    checks++; if ({in_ready, hls_a, hls_g} !== {1'b0, b[0], b[6]}) begin
      errors++; $display("FAIL b2b_accB got r=%b a=%0d g=%0d want r=0 a=-8 g=4", in_ready, hls_a, hls_g); end
    wait_out(ok, lat);
    checks++; if ({ok, out_k, out_l, out_cycles} !== {1'b1, 16'sd5, -16'sd7, 8'd12}) begin
      errors++; $display("FAIL b2b_resB got k=%0d l=%0d cyc=%0d want k=5 l=-7 cyc=12", out_k, out_l, out_cycles); end
    tick(); out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_takeB got %b want 0", out_valid); end
  endtask

  task automatic test_watchdog();
    word_t o [7];
    bit ok; int lat, r0;
    rand_ops(o); kern_hang = 1'b1; r0 = rst_hi;
    accept(o, ok);
    wait_out(ok, lat);
    checks++; if ({ok, out_err, out_k, out_l, out_cycles} !== {1'b1, 1'b1, 16'sd0, 16'sd0, 8'd63}) begin
      errors++; $display("FAIL wd_result got err=%b k=%0d l=%0d cyc=%0d want err=1 k=0 l=0 cyc=63",
        out_err, out_k, out_l, out_cycles); end
    checks++; if (rst_hi - r0 !== 1 || lat !== MAXC + 1 || kst !== 4'd0) begin
      errors++; $display("FAIL wd_pulse got pulses=%0d lat=%0d kst=%0d want 1,%0d,0", rst_hi - r0, lat, kst, MAXC + 1); end
    take(); kern_hang = 1'b0;
    rand_ops(o);
    accept(o, ok);
    wait_out(ok, lat);
    checks++; if ({ok, out_err, out_k, out_l, out_cycles} !== {1'b1, 1'b0, ref_k(o), ref_l(o), 8'd12}) begin
      errors++; $display("FAIL wd_next got err=%b k=%0d l=%0d cyc=%0d want err=0 k=%0d l=%0d cyc=12",
        out_err, out_k, out_l, out_cycles, ref_k(o), ref_l(o)); end
    take();
  endtask

  task automatic test_rst_midrun();
    word_t o [7];
    bit ok; int lat, bad;
    rand_ops(o);
    accept(o, ok);
    for (int i = 0; i < 5; i++) tick();
    Rst = 1'b1; tick(); Rst = 1'b0; #1;
    checks++; if ({in_ready, out_valid, hls_start, hls_rst, kst} !== {4'b1000, 4'd0}) begin
      errors++; $display("FAIL rst_mid got r=%b v=%b s=%b hr=%b kst=%0d want 1,0,0,0,0",
        in_ready, out_valid, hls_start, hls_rst, kst); end
    bad = 0;
    for (int i = 0; i < 20; i++) begin if (out_valid !== 1'b0 || hls_start !== 1'b0) bad++; tick(); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL rst_quiet got %0d active cycles want 0", bad); end
    rand_ops(o);
    accept(o, ok);
    wait_out(ok, lat);
    checks++; if ({ok, out_err, out_k, out_l} !== {1'b1, 1'b0, ref_k(o), ref_l(o)}) begin
      errors++; $display("FAIL rst_next got k=%0d l=%0d want k=%0d l=%0d", out_k, out_l, ref_k(o), ref_l(o)); end
    take();
  endtask

  task automatic test_stale_done();
    word_t o [7];
    bit ok; int lat, s0;
    rand_ops(o); s0 = start_hi;
    inj_en = 1'b1; inj_val = 1'bx;
    accept(o, ok);
    checks++; if ({out_valid, hls_start} !== 2'b01) begin
      errors++; $display("FAIL stale_c0 got v=%b s=%b want v=0 s=1", out_valid, hls_start); end
    tick(); inj_val = 1'b1; #1;
    checks++; if ({out_valid, hls_start} !== 2'b01) begin
      errors++; $display("FAIL stale_c1 got v=%b s=%b want v=0 s=1", out_valid, hls_start); end
    tick(); inj_en = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stale_c2 got v=%b want 0", out_valid); end
    wait_out(ok, lat);
    checks++; if ({ok, out_cycles, out_k, out_l} !== {1'b1, 8'd12, ref_k(o), ref_l(o)}) begin
      errors++; $display("FAIL stale_res got cyc=%0d k=%0d l=%0d want cyc=12 k=%0d l=%0d",
        out_cycles, out_k, out_l, ref_k(o), ref_l(o)); end
    checks++; if (start_hi - s0 !== 12) begin errors++; $display("FAIL stale_start got %0d want 12", start_hi - s0); end
    take();
  endtask

  task automatic test_random_jobs();
    word_t o [7]; word_t n [7];
    bit ok, hang; int lat, dly;
    for (int j = 0; j < 15; j++) begin
      rand_ops(o); rand_ops(n);
      hang = ($urandom_range(4) == 0);
      kern_hang = hang;
      accept(o, ok);
      set_ops(n); in_valid = 1'($urandom_range(1)); out_ready = 1'($urandom_range(1));
      wait_out(ok, lat);
      in_valid = 1'b0;
      checks++;
      if (hang ? ({ok, out_err, out_k, out_l, out_cycles} !== {1'b1, 1'b1, 16'sd0, 16'sd0, 8'd63})
               : ({ok, out_err, out_k, out_l, out_cycles} !== {1'b1, 1'b0, ref_k(o), ref_l(o), 8'd12})) begin
        errors++; $display("FAIL rand_job %0d got err=%b k=%0d l=%0d cyc=%0d want hang=%b k=%0d l=%0d",
          j, out_err, out_k, out_l, out_cycles, hang, ref_k(o), ref_l(o));
      end
      if (out_ready !== 1'b1) begin
        dly = $urandom_range(4);
        for (int i = 0; i < dly; i++) tick();
      end
      take(); kern_hang = 1'b0;
    end
    checks++; if (op_moved !== 1'b0) begin errors++; $display("FAIL ops_stable got moved want stable"); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_nominal();
    test_hold();
    test_back_to_back();
    test_watchdog();
    test_rst_midrun();
    test_stale_done();
    test_random_jobs();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
